// File: rtl/packet_decode_pkg.sv
// packet_decode_pkg: framing constants shared by the receive-side decoder and the future encoder
package packet_decode_pkg;
    localparam logic [2:0] HUNT = 3'd0;
    localparam logic [2:0] LEN  = 3'd1;
    localparam logic [2:0] DATA = 3'd2;
    localparam logic [2:0] CHK  = 3'd3;
    localparam logic [2:0] SEND = 3'd4;
    localparam logic [7:0] SYNC_DEF = 8'hA5;
    function automatic logic len_ok(input logic [7:0] l, input int depth);
        return l != 8'd0 && int'(l) <= depth;
    endfunction
endpackage

// File: rtl/packet_buffer.sv
// packet_buffer: simple dual-port payload store, sync write and registered read so it maps to EBR
module packet_buffer #(
    parameter int DEPTH = 16,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [7:0]    wd,
    input  logic [AW-1:0] ra,
    output logic [7:0]    rq
);
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rq <= mem[ra];
    end
endmodule

// File: rtl/packet_decode.sv
// packet_decode: hunts SYNC, buffers a LEN-byte payload, verifies the checksum and forwards
// only verified payloads store-and-forward; discarded packets pulse bad
module packet_decode
    import packet_decode_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter logic [7:0] SYNC = SYNC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_stb,
    input  logic [7:0] rx_dat,
    input  logic       rx_err,
    output logic       rx_rdy,
    output logic       out_stb,
    output logic [7:0] out_dat,
    output logic       out_lst,
    input  logic       out_rdy,
    output logic       bad
);
    localparam int AW = $clog2(DEPTH);
    localparam int W = AW + 1;
    logic [2:0] state;
    logic [W-1:0] len, wr, rd;
    logic [7:0] sum, ram_q;
    logic [AW-1:0] ra;
    logic take, rd_last, wr_last;
    assign take = rx_stb & ~rx_err;
    assign rd_last = rd == len - W'(1);
    assign wr_last = wr == len - W'(1);
    assign rx_rdy = state != SEND;
    assign out_stb = state == SEND;
    assign out_lst = out_stb & rd_last;
    assign out_dat = out_stb ? ram_q : 8'd0;
    // Look one byte ahead on an accepted transfer so the registered read never leaves a bubble
    assign ra = !out_stb ? '0 : out_rdy ? AW'(rd + W'(1)) : rd[AW-1:0];
    packet_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk(clk),
        .we(state == DATA && take),
        .wa(wr[AW-1:0]),
        .wd(rx_dat),
        .ra(ra),
        .rq(ram_q)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
            len <= '0;
            wr <= '0;
            rd <= '0;
            sum <= '0;
            bad <= 1'b0;
        end else begin
            bad <= 1'b0;
            case (state)
                HUNT: if (take && rx_dat == SYNC) state <= LEN;
                LEN:
                    if (rx_err || (rx_stb && !len_ok(rx_dat, DEPTH))) begin
                        bad <= 1'b1;
                        state <= HUNT;
                    end else if (rx_stb) begin
                        len <= W'(rx_dat);
                        sum <= rx_dat;
                        wr <= '0;
                        state <= DATA;
                    end
                DATA:
                    if (rx_err) begin
                        bad <= 1'b1;
                        state <= HUNT;
                    end else if (rx_stb) begin
                        sum <= sum + rx_dat;
                        wr <= wr + W'(1);
                        if (wr_last) state <= CHK;
                    end
                CHK:
                    if (rx_err || (rx_stb && sum + rx_dat != 8'd0)) begin
                        bad <= 1'b1;
                        state <= HUNT;
                    end else if (rx_stb) begin
                        rd <= '0;
                        state <= SEND;
                    end
                SEND:
                    if (out_rdy) begin
                        rd <= rd + W'(1);
                        if (rd_last) state <= HUNT;
                    end
                default: state <= HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_packet_decode.sv
// tb_packet_decode: directed frames with a payload scoreboard popped on each output transfer
module tb_packet_decode;
    import packet_decode_pkg::*;
    localparam int DEPTH = 16;
    logic clk = 1'b0, rst_n = 1'b0, rx_stb = 1'b0, rx_err = 1'b0, out_rdy = 1'b1;
    logic [7:0] rx_dat = 8'd0;
    logic rx_rdy, out_stb, out_lst, bad;
    logic [7:0] out_dat;
    int n_chk = 0, n_fail = 0, bad_seen = 0, bad_exp = 0;
    logic [8:0] sb[$];
    logic hold_prev = 1'b0, bad_prev = 1'b0;
    logic [8:0] prev_out = 9'd0;

    always #5 clk = ~clk;

    packet_decode #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rx_stb(rx_stb), .rx_dat(rx_dat), .rx_err(rx_err),
        .rx_rdy(rx_rdy), .out_stb(out_stb), .out_dat(out_dat), .out_lst(out_lst),
        .out_rdy(out_rdy), .bad(bad)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
            bad_prev = 1'b0;
        end else begin
            if (bad) begin
                bad_seen++;
                check("bad_one_cycle", 32'(bad_prev), 0);
            end
            if (out_stb) check("rx_rdy_in_send", 32'(rx_rdy), 0);
            if (hold_prev) begin
                check("stb_held", 32'(out_stb), 1);
                check("out_held", 32'({out_lst, out_dat}), 32'(prev_out));
            end
            if (out_stb && out_rdy) begin
                if (sb.size() == 0) check("spurious_out", 32'(out_stb), 0);
                else check("payload", 32'({out_lst, out_dat}), 32'(sb.pop_front()));
            end
            hold_prev = out_stb & ~out_rdy;
            prev_out = {out_lst, out_dat};
            bad_prev = bad;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_stb = 1'b1;
        rx_dat = b;
        while (!rx_rdy && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("rx_timeout", 32'(rx_rdy), 1);
        tick();
        rx_stb = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [7:0] base, input bit good);
        logic [7:0] s = 8'(len);
        logic [7:0] b;
        send_byte(SYNC_DEF);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) begin
            b = base + 8'(i);
            s = s + b;
            if (good) sb.push_back({i == len - 1, b});
            send_byte(b);
        end
        if (!good) bad_exp++;
        send_byte(good ? 8'(8'd0 - s) : 8'(8'd0 - s - 8'd1));
    endtask

    task automatic drain;
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain", 32'(sb.size()), 0);
    endtask

    initial begin
        #1;
        check("rst_out_stb", 32'(out_stb), 0);
        check("rst_out_lst", 32'(out_lst), 0);
        check("rst_out_dat", 32'(out_dat), 0);
        check("rst_bad", 32'(bad), 0);
        check("rst_rx_rdy", 32'(rx_rdy), 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        // basic frame, 3 consecutive output cycles
        send_frame(3, 8'h01, 1'b1);
        check("lat_stb", 32'(out_stb), 1);
        check("first_dat", 32'(out_dat), 32'h01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("burst_stb", 32'(out_stb), 1);
        end
        @(negedge clk);
        check("stb_drop", 32'(out_stb), 0);
        tick();
        check("t1_sb", 32'(sb.size()), 0);
        // bad checksum
        send_frame(3, 8'h01, 1'b0);
        check("chk_bad_pulse", 32'(bad), 1);
        check("chk_bad_no_stb", 32'(out_stb), 0);
        tick();
        check("chk_bad_clear", 32'(bad), 0);
        check("chk_bad_hunt", 32'(rx_rdy), 1);
        // leading junk
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check("junk_no_bad", 32'(bad), 0);
        send_frame(3, 8'h01, 1'b1);
        drain();
        // illegal lengths
        send_byte(SYNC_DEF);
        send_byte(8'h00);
        check("len0_bad", 32'(bad), 1);
        bad_exp++;
        send_byte(SYNC_DEF);
        send_byte(8'h11);
        check("len17_bad", 32'(bad), 1);
        bad_exp++;
        send_frame(3, 8'h20, 1'b1);
        drain();
        send_frame(DEPTH, 8'h30, 1'b1);
        drain();
        send_frame(2, 8'hA4, 1'b1);
        drain();
        // consumer stall on byte 02, next SYNC held off until the packet drains
        send_frame(3, 8'h01, 1'b1);
        tick();
        out_rdy = 1'b0;
        rx_stb = 1'b1;
        rx_dat = SYNC_DEF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_dat", 32'(out_dat), 32'h02);
            check("stall_rx_rdy", 32'(rx_rdy), 0);
        end
        out_rdy = 1'b1;
        send_frame(3, 8'h40, 1'b1);
        drain();
        // framing error on second payload byte
        send_byte(SYNC_DEF);
        send_byte(8'h03);
        send_byte(8'h01);
        rx_stb = 1'b1;
        rx_err = 1'b1;
        rx_dat = 8'h02;
        tick();
        rx_stb = 1'b0;
        rx_err = 1'b0;
        check("err_bad", 32'(bad), 1);
        bad_exp++;
        send_byte(8'h03);
        send_byte(8'hF7);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("err_no_out", 32'(out_stb), 0);
        end
        rx_err = 1'b1;
        tick();
        rx_err = 1'b0;
        tick();
        check("hunt_err_ignored", 32'(bad), 0);
        // asynchronous reset while sending
        out_rdy = 1'b0;
        send_frame(2, 8'h50, 1'b1);
        check("pre_rst_stb", 32'(out_stb), 1);
        check("pre_rst_dat", 32'(out_dat), 32'h50);
        #2 rst_n = 1'b0;
        #1;
        check("arst_stb", 32'(out_stb), 0);
        check("arst_dat", 32'(out_dat), 0);
        check("arst_lst", 32'(out_lst), 0);
        check("arst_rx_rdy", 32'(rx_rdy), 1);
        sb.delete();
        out_rdy = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        // reset mid-DATA loses the packet silently
        send_byte(SYNC_DEF);
        send_byte(8'h03);
        send_byte(8'h01);
        #2 rst_n = 1'b0;
        #1;
        check("drst_bad", 32'(bad), 0);
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(3, 8'h01, 1'b1);
        drain();
        for (int i = 0; i < 5; i++) tick();
        check("bad_count", 32'(bad_seen), 32'(bad_exp));
        check("sb_final", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
